sram_port_arbiter: RTL and testbench

// Shares the single external SRAM controller port between NUM_REQ requesters:

---
 rtl/sram_port_arbiter_if.sv | 33 +++
 rtl/sram_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_sram_port_arbiter.sv | 311 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_port_arbiter_if.sv
// Signal bundle between the SRAM port arbiter, its requesters and the SRAM controller.
// The arbiter takes the slave view; the requester/controller side takes the master view.
interface sram_port_arbiter_if #(
  parameter int NUM_REQ = 3
);
  logic [NUM_REQ-1:0]    req_i;
  logic [NUM_REQ-1:0]    acc_i;
  logic [NUM_REQ-1:0]    we_n_i;
  logic [NUM_REQ*18-1:0] addr_i;
  logic [NUM_REQ*16-1:0] wdata_i;
  logic [NUM_REQ-1:0]    grant_o;
  logic [17:0]           SRAM_address_o;
  logic [15:0]           SRAM_write_data_o;
  logic                  SRAM_we_n_o;
  logic [15:0]           SRAM_read_data_i;
  logic [15:0]           rdata_o;
  logic [NUM_REQ-1:0]    rvalid_o;
  logic [NUM_REQ-1:0]    wr_violation_o;
  logic                  clear_violation_i;
  logic                  busy_o;

  modport slave (
    input  req_i, acc_i, we_n_i, addr_i, wdata_i, SRAM_read_data_i, clear_violation_i,
    output grant_o, SRAM_address_o, SRAM_write_data_o, SRAM_we_n_o, rdata_o, rvalid_o,
           wr_violation_o, busy_o
  );

  modport master (
    output req_i, acc_i, we_n_i, addr_i, wdata_i, SRAM_read_data_i, clear_violation_i,
    input  grant_o, SRAM_address_o, SRAM_write_data_o, SRAM_we_n_o, rdata_o, rvalid_o,
           wr_violation_o, busy_o
  );
endinterface

// File: rtl/sram_port_arbiter.sv
// Lock-until-release arbiter sharing one SRAM controller port between NUM_REQ requesters,
// with tagged read-data return and write protection of the source-data region.
module sram_port_arbiter #(
  parameter int NUM_REQ      = 3,
  parameter int READ_LATENCY = 2,
  parameter int ROUND_ROBIN  = 0,
  parameter int PROT_LIMIT   = 146944
) (
  input  logic                Clock,
  input  logic                Resetn,
  sram_port_arbiter_if.slave  bus
);

  localparam int          IDX_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [17:0] PROT_LIM = 18'(PROT_LIMIT);

  typedef enum logic {S_IDLE, S_OWN} state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [NUM_REQ-1:0] viol_q, viol_d;

  logic [READ_LATENCY-1:0] tag_vld_q, tag_vld_d;
  logic [IDX_W-1:0]        tag_idx_q [READ_LATENCY];
  logic [IDX_W-1:0]        tag_idx_d [READ_LATENCY];

  logic             win_found;
  logic [IDX_W-1:0] win_idx;
  logic [17:0]      own_addr;
  logic [15:0]      own_wdata;
  logic             acc_vld, prot, wr_ok, wr_bad, rd_issue;

  // Winner search; in rotating mode the scan starts at the pointer and wraps.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    win_found = 1'b0;
    win_idx   = '0;
    cand      = 0;
    cand_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = k + ((ROUND_ROBIN != 0) ? int'(rr_ptr_q) : 0);
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!win_found && bus.req_i[cand_idx]) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
      end
    end
  end

  // Owner access decode; an owner dropping req_i in the same cycle has its access ignored.
  always_comb begin
    own_addr  = bus.addr_i[int'(owner_q)*18 +: 18];
    own_wdata = bus.wdata_i[int'(owner_q)*16 +: 16];
    acc_vld   = (state_q == S_OWN) && bus.acc_i[owner_q] && bus.req_i[owner_q]
                && grant_q[owner_q];
    prot      = (owner_q != '0) && (own_addr < PROT_LIM);
    wr_ok     = acc_vld && !bus.we_n_i[owner_q] && !prot;
    wr_bad    = acc_vld && !bus.we_n_i[owner_q] && prot;
    rd_issue  = acc_vld && bus.we_n_i[owner_q];
  end

  assign bus.SRAM_address_o    = acc_vld ? own_addr  : 18'd0;
  assign bus.SRAM_write_data_o = acc_vld ? own_wdata : 16'd0;
  assign bus.SRAM_we_n_o       = ~wr_ok;
  assign bus.rdata_o           = bus.SRAM_read_data_i;
  assign bus.grant_o           = grant_q;
  assign bus.busy_o            = |grant_q;
  assign bus.wr_violation_o    = viol_q;
  assign bus.rvalid_o          = tag_vld_q[READ_LATENCY-1]
                                 ? (NUM_REQ'(1) << tag_idx_q[READ_LATENCY-1]) : '0;

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      S_IDLE: begin
        if (win_found) begin
          state_d  = S_OWN;
          owner_d  = win_idx;
          grant_d  = NUM_REQ'(1) << win_idx;
          rr_ptr_d = (win_idx == IDX_W'(NUM_REQ - 1)) ? '0 : win_idx + IDX_W'(1);
        end
      end
      S_OWN: begin
        if (!bus.req_i[owner_q]) begin
          state_d = S_IDLE;
          grant_d = '0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // A new violation beats a simultaneous clear.
  always_comb begin
    viol_d = bus.clear_violation_i ? '0 : viol_q;
    if (wr_bad) viol_d[owner_q] = 1'b1;
  end

  always_comb begin
    tag_vld_d    = '0;
    tag_idx_d    = tag_idx_q;
    tag_vld_d[0] = rd_issue;
    tag_idx_d[0] = owner_q;
    for (int s = 1; s < READ_LATENCY; s++) begin
      tag_vld_d[s] = tag_vld_q[s-1];
      tag_idx_d[s] = tag_idx_q[s-1];
    end
  end

  // Control state stage
  always_ff @(posedge Clock or negedge Resetn) begin
    if (!Resetn) begin
      state_q   <= S_IDLE;
      owner_q   <= '0;
      rr_ptr_q  <= '0;
      grant_q   <= '0;
      viol_q    <= '0;
      tag_vld_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      rr_ptr_q  <= rr_ptr_d;
      grant_q   <= grant_d;
      viol_q    <= viol_d;
      tag_vld_q <= tag_vld_d;
    end
  end

  // Read tag payload stage; only meaningful where the matching valid bit is set
  always_ff @(posedge Clock) begin
    tag_idx_q <= tag_idx_d;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed plus randomized bench for sram_port_arbiter: a fixed-priority and a round-robin
// instance share one stimulus stream and are scored against a cycle-level reference model.
module tb_sram_port_arbiter;
  localparam int N    = 3;
  localparam int L    = 2;
  localparam int PROT = 146944;

  logic Clock = 1'b0;
  logic Resetn;
  always #5 Clock = ~Clock;

  sram_port_arbiter_if #(.NUM_REQ(N)) if_fp ();
  sram_port_arbiter_if #(.NUM_REQ(N)) if_rr ();

  assign if_rr.req_i             = if_fp.req_i;
  assign if_rr.acc_i             = if_fp.acc_i;
  assign if_rr.we_n_i            = if_fp.we_n_i;
  assign if_rr.addr_i            = if_fp.addr_i;
  assign if_rr.wdata_i           = if_fp.wdata_i;
  assign if_rr.SRAM_read_data_i  = if_fp.SRAM_read_data_i;
  assign if_rr.clear_violation_i = if_fp.clear_violation_i;

  sram_port_arbiter #(.NUM_REQ(N), .READ_LATENCY(L), .ROUND_ROBIN(0), .PROT_LIMIT(PROT))
    u_fp (.Clock(Clock), .Resetn(Resetn), .bus(if_fp.slave));
  sram_port_arbiter #(.NUM_REQ(N), .READ_LATENCY(L), .ROUND_ROBIN(1), .PROT_LIMIT(PROT))
    u_rr (.Clock(Clock), .Resetn(Resetn), .bus(if_rr.slave));

  // stimulus
  logic [N-1:0] req, acc, wen;
  logic [17:0]  a  [N];
  logic [15:0]  wd [N];
  logic         clr;
  logic [15:0]  rd;

  // reference model: index 0 = fixed priority, 1 = round robin
  int           m_own [2];
  int           m_ptr [2];
  logic [N-1:0] m_viol [2];
  logic [N-1:0] m_ring [2][16];
  int           cyc;

  int n_cmp = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic apply();
    if_fp.req_i  = req;
    if_fp.acc_i  = acc;
    if_fp.we_n_i = wen;
    for (int k = 0; k < N; k++) begin
      if_fp.addr_i[k*18 +: 18]  = a[k];
      if_fp.wdata_i[k*16 +: 16] = wd[k];
    end
    if_fp.clear_violation_i = clr;
    if_fp.SRAM_read_data_i  = rd;
  endtask

  function automatic int arb(input logic [N-1:0] r, input int ptr, input bit rr);
    int start = rr ? ptr : 0;
    for (int k = 0; k < N; k++) begin
      int i = (start + k) % N;
      if (r[i]) return i;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_own[d]  = -1;
      m_ptr[d]  = 0;
      m_viol[d] = '0;
      for (int i = 0; i < 16; i++) m_ring[d][i] = '0;
    end
  endtask

  task automatic check_out(input int d, input string pfx, input logic [N-1:0] g,
                           input logic [17:0] ad, input logic [15:0] wdo, input logic we,
                           input logic [15:0] rdo, input logic [N-1:0] rv,
                           input logic [N-1:0] vi, input logic bz);
    int           o = m_own[d];
    logic         v = 1'b0;
    logic         p = 1'b0;
    logic [N-1:0] eg = '0;
    logic [17:0]  ea = '0;
    logic         ewe = 1'b1;
    if (o >= 0) begin
      v  = acc[o] && req[o];
      eg = N'(1) << o;
      if (o > 0) p = (int'(a[o]) < PROT);
      if (v) ea = a[o];
      if (v && !wen[o] && !p) ewe = 1'b0;
    end
    chk({pfx, "_grant"}, 32'(g), 32'(eg));
    chk({pfx, "_busy"}, 32'(bz), 32'(o >= 0));
    chk({pfx, "_addr"}, 32'(ad), 32'(ea));
    chk({pfx, "_we_n"}, 32'(we), 32'(ewe));
    chk({pfx, "_rdata"}, 32'(rdo), 32'(rd));
    chk({pfx, "_rvalid"}, 32'(rv), 32'(m_ring[d][cyc % 16]));
    chk({pfx, "_viol"}, 32'(vi), 32'(m_viol[d]));
    if (v) chk({pfx, "_wdata"}, 32'(wdo), 32'(wd[o]));
  endtask

  task automatic model_adv(input int d);
    int           o = m_own[d];
    logic         v = 1'b0;
    logic         p = 1'b0;
    logic [N-1:0] nv;
    if (o >= 0) begin
      v = acc[o] && req[o];
      if (o > 0) p = (int'(a[o]) < PROT);
    end
    m_ring[d][cyc % 16] = '0;
    nv = clr ? '0 : m_viol[d];
    if (v && !wen[o] && p) nv[o] = 1'b1;
    m_viol[d] = nv;
    if (v && wen[o]) m_ring[d][(cyc + L) % 16][o] = 1'b1;
    if (o < 0) begin
      int w = arb(req, m_ptr[d], d == 1);
      if (w >= 0) begin
        m_own[d] = w;
        m_ptr[d] = (w + 1) % N;
      end
    end else if (!req[o]) begin
      m_own[d] = -1;
    end
  endtask

  // One clock cycle: drive, check mid-cycle, advance the model, land just after the edge.
  task automatic step();
    apply();
    @(negedge Clock);
    check_out(0, "fp", if_fp.grant_o, if_fp.SRAM_address_o, if_fp.SRAM_write_data_o,
              if_fp.SRAM_we_n_o, if_fp.rdata_o, if_fp.rvalid_o, if_fp.wr_violation_o,
              if_fp.busy_o);
    check_out(1, "rr", if_rr.grant_o, if_rr.SRAM_address_o, if_rr.SRAM_write_data_o,
              if_rr.SRAM_we_n_o, if_rr.rdata_o, if_rr.rvalid_o, if_rr.wr_violation_o,
              if_rr.busy_o);
    model_adv(0);
    model_adv(1);
    cyc++;
    @(posedge Clock);
    #1;
  endtask

  task automatic do_reset(input int n);
    Resetn = 1'b0;
    req = '0;
    acc = '0;
    model_reset();
    apply();
    repeat (n) begin
      @(negedge Clock);
      check_out(0, "rst_fp", if_fp.grant_o, if_fp.SRAM_address_o, if_fp.SRAM_write_data_o,
                if_fp.SRAM_we_n_o, if_fp.rdata_o, if_fp.rvalid_o, if_fp.wr_violation_o,
                if_fp.busy_o);
      check_out(1, "rst_rr", if_rr.grant_o, if_rr.SRAM_address_o, if_rr.SRAM_write_data_o,
                if_rr.SRAM_we_n_o, if_rr.rdata_o, if_rr.rvalid_o, if_rr.wr_violation_o,
                if_rr.busy_o);
      chk("rst_wdata", 32'(if_fp.SRAM_write_data_o), 32'd0);
    end
    @(posedge Clock);
    #1;
    Resetn = 1'b1;
  endtask

  initial begin
    int          held [N];
    int          order [$];
    int          exp_ord [4];
    logic [N-1:0] prev_g;
    int          own_before;

    req = '0; acc = '0; wen = '1; clr = 1'b0; rd = 16'h5a5a; cyc = 0;
    for (int k = 0; k < N; k++) begin
      a[k]  = '0;
      wd[k] = '0;
    end
    do_reset(3);

    // fixed priority win and handover
    req = 3'b110;
    step();
    chk("fp_first_grant", 32'(if_fp.grant_o), 32'h2);
    step();
    req = 3'b100;
    step();
    chk("fp_release", 32'(if_fp.grant_o), 32'h0);
    step();
    chk("fp_handover", 32'(if_fp.grant_o), 32'h4);

    // back-to-back reads from owner 2
    for (int i = 0; i < 4; i++) begin
      acc = 3'b100; wen = 3'b111; a[2] = 18'h24000 + 18'(i); rd = 16'(i * 3 + 1);
      step();
    end
    acc = '0;
    step();
    step();

    // read tag delivered across an ownership change
    req = 3'b101; acc = 3'b100; wen = 3'b111; a[2] = 18'h24008;
    step();
    req = 3'b001; acc = '0;
    step();
    chk("ho_rvalid", 32'(if_fp.rvalid_o), 32'h4);
    chk("ho_gap", 32'(if_fp.grant_o), 32'h0);
    step();
    chk("ho_new_grant", 32'(if_fp.grant_o), 32'h1);

    // requester 0 may write inside the protected region
    acc = 3'b001; wen = 3'b110; a[0] = 18'd100; wd[0] = 16'h1234;
    apply();
    #1;
    chk("own0_we_n", 32'(if_fp.SRAM_we_n_o), 32'h0);
    step();
    chk("own0_viol", 32'(if_fp.wr_violation_o), 32'h0);
    req = '0; acc = '0; wen = '1;
    step();
    step();
    req = 3'b010;
    step();

    // requester 1 protected write is dropped and flagged
    acc = 3'b010; wen = 3'b101; a[1] = 18'd100; wd[1] = 16'h1234;
    apply();
    #1;
    chk("prot_we_n", 32'(if_fp.SRAM_we_n_o), 32'h1);
    chk("prot_addr", 32'(if_fp.SRAM_address_o), 32'd100);
    step();
    chk("prot_viol", 32'(if_fp.wr_violation_o), 32'h2);
    clr = 1'b1;
    step();
    chk("prot_set_wins", 32'(if_fp.wr_violation_o), 32'h2);
    acc = '0;
    step();
    chk("prot_cleared", 32'(if_fp.wr_violation_o), 32'h0);
    clr = 1'b0;

    // owner drops request with a strobed access: ignored
    req = '0; acc = 3'b010; wen = 3'b101;
    step();
    chk("drop_acc_viol", 32'(if_fp.wr_violation_o), 32'h0);
    acc = '0; wen = '1;

    // reset with two reads in flight
    req = 3'b100;
    step();
    acc = 3'b100; wen = 3'b111; a[2] = 18'h24010;
    step();
    a[2] = 18'h24011;
    apply();
    @(negedge Clock);
    do_reset(2);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("rst_no_rvalid", 32'(if_rr.rvalid_o | if_fp.rvalid_o), 32'h0);
    end

    // rotating priority: hold 4 cycles, release one cycle, re-request
    for (int k = 0; k < N; k++) held[k] = 0;
    prev_g = '0;
    for (int c = 0; c < 22; c++) begin
      for (int k = 0; k < N; k++) req[k] = !(m_own[1] == k && held[k] >= 4);
      own_before = m_own[1];
      step();
      if (own_before >= 0) begin
        if (req[own_before]) held[own_before]++;
        else held[own_before] = 0;
      end
      if (if_rr.grant_o != '0 && if_rr.grant_o != prev_g)
        for (int k = 0; k < N; k++) if (if_rr.grant_o[k]) order.push_back(k);
      prev_g = if_rr.grant_o;
    end
    exp_ord = '{0, 1, 2, 0};
    chk("rr_order_len", 32'(order.size() >= 4), 32'h1);
    for (int i = 0; i < 4; i++)
      if (i < order.size()) chk("rr_order", 32'(order[i]), 32'(exp_ord[i]));
    req = '0;
    step();
    step();

    // randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < N; k++) begin
        if ($urandom_range(0, 5) == 0) req[k] = ~req[k];
        acc[k] = 1'($urandom_range(0, 1));
        wen[k] = 1'($urandom_range(0, 1));
        wd[k]  = 16'($urandom);
        case ($urandom_range(0, 3))
          0:       a[k] = 18'($urandom_range(0, PROT - 1));
          1:       a[k] = 18'(PROT - 1 + $urandom_range(0, 1));
          default: a[k] = 18'($urandom);
        endcase
      end
      clr = ($urandom_range(0, 15) == 0);
      rd  = 16'($urandom);
      step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
